// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clk on sout, framed by sframe, back-to-back capable.
module piso_shift_tx #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PREV_CNT = CW'(WIDTH - 2);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             accept;

  assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
  assign din_ready = !reset && ((state == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;

  // shreg holds only the bits still to be sent; the current bit already sits in sout.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      sout   <= IDLE_LEVEL;
      sframe <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      cnt    <= '0;
      sframe <= 1'b1;
      busy   <= 1'b1;
      done   <= 1'b0;
      if (MSB_FIRST) begin
        sout  <= din[WIDTH-1];
        shreg <= {din[WIDTH-2:0], 1'b0};
      end else begin
        sout  <= din[0];
        shreg <= {1'b0, din[WIDTH-1:1]};
      end
    end else if (state == SHIFT) begin
      if (cnt == LAST_CNT) begin
        state  <= IDLE;
        cnt    <= '0;
        sout   <= IDLE_LEVEL;
        sframe <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        done <= (cnt == PREV_CNT);
        if (MSB_FIRST) begin
          sout  <= shreg[WIDTH-1];
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          sout  <= shreg[0];
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in/serial-out transmitter. It is the sending end of the team's single-bit serial capture path, whose per-bit storage is a synchronous-reset D flip-flop.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clk on sout, qualified by sframe.
- Supports back-to-back words with no idle gap. Sits between a parallel data producer and the serial link.

Parameters:
WIDTH, 8, data word width in bits; legal range >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 0, value driven on sout when no word is being sent.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
din  input  WIDTH  parallel word; sampled only on an accept edge.
din_valid  input  1  producer has a word on din.
din_ready  output  1  block can accept din this cycle.
sout  output  1  serial data bit.
sframe  output  1  high while sout carries a valid data bit.
done  output  1  one-cycle pulse in the cycle the last bit of a word is on sout.
busy  output  1  high while a word is in transmission (same as sframe).

Behaviour:
- Reset: clk, reset. Reset is synchronous and active-high. On a rising clk edge with reset=1, the block sets:
  - state=IDLE, bit counter=0, shift register=0;
  - sout=IDLE_LEVEL, sframe=0, done=0, busy=0.
  - Reset overrides every other input, including an in-progress word (that word is aborted with no done pulse) and a simultaneous accept.
- din_ready is combinational:
  - din_ready = !reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
  - It does not depend on din_valid.
- Accept: a word is accepted on a rising edge where din_valid && din_ready. din is captured on that edge only. din changes at any other time are ignored.
- States:
  - IDLE: sout=IDLE_LEVEL, sframe=0. On accept, go to SHIFT with cnt=0.
  - SHIFT: sout = current bit, sframe=1, busy=1. cnt increments each cycle.
    - At cnt==WIDTH-1 (the last bit), done=1.
    - If an accept occurs on that edge, go to SHIFT with cnt=0 and the new word: back-to-back, sframe stays high continuously.
    - Otherwise go to IDLE.
- Latency: the first bit appears on sout in the cycle immediately after the accept edge. Each word occupies exactly WIDTH consecutive cycles of sframe=1.
- Bit order:
  - MSB_FIRST=1: the bits sent are din[WIDTH-1], din[WIDTH-2], …, din[0].
  - MSB_FIRST=0: the bits sent are din[0] … din[WIDTH-1].
- All outputs except din_ready are registered (driven from flops). Throughput is one word per WIDTH cycles.
- Counter width is $clog2(WIDTH). There is no wrap beyond WIDTH-1; the counter is reloaded to 0 on accept.
- din_valid held high while mid-word (cnt < WIDTH-1) has no effect. The producer must hold din_valid and din until din_ready.
- done and sframe fall together on the cycle after the last bit, unless a back-to-back accept occurred.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, accept din=8'hA5 → starting the next cycle, sout=1,0,1,0,0,1,0,1; sframe=1 for exactly 8 cycles; done=1 only on the 8th; then sout=0 and din_ready=1.
2. Back-to-back: 8'hA5 accepted, din_valid held with 8'h3C, accepted on A5's last-bit edge → 16 contiguous sframe cycles carrying A5 then 0,0,1,1,1,1,0,0; done pulses on cycles 8 and 16.
3. MSB_FIRST=0, din=8'h01 → sout=1,0,0,0,0,0,0,0; IDLE_LEVEL=1 variant: sout=1 before and after the frame.
4. Hold din_valid=1 with 8'hFF while sending 8'h00 → din_ready=0 for cycles 1–7 and 1 on cycle 8; 8'hFF is not accepted early; it is accepted on cycle 8's edge.
5. Reset asserted after 3 bits of 8'hA5 → next cycle sout=IDLE_LEVEL, sframe=0, busy=0, no done. A subsequent accept of 8'h81 transmits in full from bit 7.
6. Reset and accept on the same edge → word not captured; outputs at reset values; din_ready=0 while reset=1.
